// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, imem and IF/ID signal bundle
//
// Groups every non-clock/reset signal of fetch_stage.
//   master : fetch stage side (drives imem request and IF/ID outputs)
//   slave  : environment side (decode control, instruction memory)
// Signals:
//   stall_i        decode cannot accept; IF/ID holds
//   redirect_i     branch/JAL taken; flush and refetch
//   redirect_pc_i  redirect target (low two bits ignored)
//   imem_req_o     one-cycle fetch request pulse
//   imem_addr_o    fetch address, always equal to the PC
//   imem_rdata_i   fetched instruction
//   imem_rvalid_i  one-cycle response strobe
//   id_valid_o     IF/ID holds a valid instruction
//   id_instr_o     IF/ID instruction word
//   id_pc_o        IF/ID instruction address
interface fetch_stage_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_rvalid_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_rdata_i, imem_rvalid_i,
    output imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_rdata_i, imem_rvalid_i,
    input  imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Owns the PC, issues single-outstanding requests to instruction memory and
// delivers instruction/PC pairs to decode. Handles decode stall, branch/jump
// redirect and squashing of a fetch that is in flight at redirect time.
// Ports:
//   clk    clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_stage_if.master (decode control, imem port, IF/ID outputs)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_q;
  logic        squash;
  logic        req_q;
  logic        id_valid_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;

  logic [31:0] pc_next;
  logic [31:0] redirect_target;
  logic        load_en;
  logic [31:0] load_data;

  assign pc_next         = pc + 32'd4;
  assign redirect_target = {bus.redirect_pc_i[31:2], 2'b00};

  // An instruction enters IF/ID either straight from a non-squashed response
  // or from the holding buffer once decode stops stalling. Redirect wins.
  always_comb begin
    load_en   = 1'b0;
    load_data = buf_q;
    if (!bus.redirect_i) begin
      if (state == WAIT && bus.imem_rvalid_i && !squash && !bus.stall_i) begin
        load_en   = 1'b1;
        load_data = bus.imem_rdata_i;
      end else if (state == HOLD && !bus.stall_i) begin
        load_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      buf_q      <= 32'h0;
      squash     <= 1'b0;
      req_q      <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= 32'h0;
    end else begin
      // Request is a registered pulse, raised only on entry to REQ.
      req_q <= 1'b0;
      if (bus.redirect_i) begin
        id_valid_q <= 1'b0;
        id_instr_q <= NOP_INSTR;
        pc         <= redirect_target;
        unique case (state)
          REQ: begin
            // The request at the old PC is already on the bus this cycle;
            // its response must be dropped.
            squash <= 1'b1;
            state  <= WAIT;
          end
          WAIT: begin
            if (bus.imem_rvalid_i) begin
              squash <= 1'b0;
              state  <= REQ;
              req_q  <= 1'b1;
            end else begin
              squash <= 1'b1;
            end
          end
          default: begin
            // IDLE or HOLD: nothing outstanding, any buffered word is stale.
            state <= REQ;
            req_q <= 1'b1;
          end
        endcase
      end else begin
        if (load_en) begin
          id_valid_q <= 1'b1;
          id_instr_q <= load_data;
          id_pc_q    <= pc;
          pc         <= pc_next;
        end else if (!bus.stall_i) begin
          id_valid_q <= 1'b0;
          id_instr_q <= NOP_INSTR;
        end

        unique case (state)
          IDLE: begin
            state <= REQ;
            req_q <= 1'b1;
          end
          REQ: begin
            state <= WAIT;
          end
          WAIT: begin
            if (bus.imem_rvalid_i) begin
              if (squash) begin
                squash <= 1'b0;
                state  <= REQ;
                req_q  <= 1'b1;
              end else if (!bus.stall_i) begin
                state <= REQ;
                req_q <= 1'b1;
              end else begin
                buf_q <= bus.imem_rdata_i;
                state <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!bus.stall_i) begin
              state <= REQ;
              req_q <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.imem_req_o  = req_q;
  assign bus.imem_addr_o = pc;
  assign bus.id_valid_o  = id_valid_q;
  assign bus.id_instr_o  = id_instr_q;
  assign bus.id_pc_o     = id_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 clk = ~clk;

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2.master)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] exp_id[$];
  logic [31:0] exp_req[$];
  logic [31:0] ovr[logic [31:0]];
  int          mem_lat  = 1;
  int          mem_cnt  = 0;
  logic [31:0] mem_data = 32'h0;
  bit          mem_keep = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push_id(input logic [31:0] pc, input logic [31:0] instr);
    exp_id.push_back({pc, instr});
  endtask

  // Instruction memory: latency mem_lat cycles, addr-as-data unless overridden.
  // Also checks request addresses against the scoreboard.
  initial begin
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      bus.imem_rvalid_i = 1'b0;
      if (!rst_n && !mem_keep) begin
        mem_cnt = 0;
      end else if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.imem_rvalid_i = 1'b1;
          bus.imem_rdata_i  = mem_data;
        end
      end
      if (rst_n && bus.imem_req_o) begin
        chk("single_outstanding", mem_cnt, 32'd0);
        if (exp_req.size() > 0) chk("req_addr", bus.imem_addr_o, exp_req.pop_front());
        mem_data = ovr.exists(bus.imem_addr_o) ? ovr[bus.imem_addr_o] : bus.imem_addr_o;
        mem_cnt  = mem_lat;
      end
    end
  end

  // Monitor: a valid IF/ID word after a non-stalled edge is a fresh delivery.
  initial begin
    logic        st;
    logic [63:0] e;
    forever begin
      @(posedge clk);
      st = bus.stall_i;
      @(negedge clk);
      if (rst_n && bus.id_valid_o && !st && exp_id.size() > 0) begin
        e = exp_id.pop_front();
        chk("id_pc", bus.id_pc_o, e[63:32]);
        chk("id_instr", bus.id_instr_o, e[31:0]);
      end
    end
  end

  // Second instance memory: fixed 1-cycle latency, addr-as-data.
  initial begin
    logic        p;
    logic [31:0] pa;
    p  = 1'b0;
    pa = 32'h0;
    bus2.imem_rvalid_i = 1'b0;
    bus2.imem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      bus2.imem_rvalid_i = p;
      bus2.imem_rdata_i  = pa;
      p  = rst2_n && bus2.imem_req_o;
      pa = bus2.imem_addr_o;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    #1;
    chk("rst_req", bus.imem_req_o, 32'd0);
    chk("rst_addr", bus.imem_addr_o, 32'h0);
    chk("rst_valid", bus.id_valid_o, 32'd0);
    chk("rst_instr", bus.id_instr_o, 32'h13);
    chk("rst_pc", bus.id_pc_o, 32'h0);
    exp_id.delete();
    exp_req.delete();
    ovr.delete();
    mem_keep = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.imem_req_o && bus.imem_addr_o == a) && n < 40);
    if (!(bus.imem_req_o && bus.imem_addr_o == a)) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_req: no request at %08h within 40 cycles", a);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_id.size() > 0 || exp_req.size() > 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, exp_id.size() + exp_req.size(), 32'd0);
    exp_id.delete();
    exp_req.delete();
  endtask

  task automatic redirect_pulse(input logic [31:0] target);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = target;
    @(negedge clk);
    bus.redirect_i    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vpat;
    logic [31:0] rpat;
    logic [31:0] e2[3];
    int          got;
    int          nreq;
    int          n;

    rst_n  = 1'b0;
    rst2_n = 1'b0;
    bus.stall_i        = 1'b0;
    bus.redirect_i     = 1'b0;
    bus.redirect_pc_i  = 32'h0;
    bus2.stall_i       = 1'b0;
    bus2.redirect_i    = 1'b0;
    bus2.redirect_pc_i = 32'h0;

    // 1: sequential fetch, 1-cycle memory, one instruction per two cycles
    do_reset();
    mem_lat = 1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    push_id(32'h0, 32'h0); push_id(32'h4, 32'h4); push_id(32'h8, 32'h8);
    release_reset();
    vpat = 32'h0;
    rpat = 32'h0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      vpat = {vpat[30:0], bus.id_valid_o};
      rpat = {rpat[30:0], bus.imem_req_o};
    end
    chk("valid_pattern", vpat, 32'h15);
    chk("req_pattern", rpat, 32'h55);
    drain("seq");

    // 2: decode stall while the response at 0x8 arrives
    do_reset();
    mem_lat = 1;
    ovr[32'h8] = 32'h0050_0093;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_req.push_back(32'h8); exp_req.push_back(32'hC);
    push_id(32'h0, 32'h0); push_id(32'h4, 32'h4);
    push_id(32'h8, 32'h0050_0093); push_id(32'hC, 32'hC);
    release_reset();
    wait_req(32'h8);
    bus.stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_no_req", bus.imem_req_o, 32'd0);
      chk("stall_hold_pc", bus.id_pc_o, 32'h4);
      chk("stall_hold_instr", bus.id_instr_o, 32'h4);
    end
    bus.stall_i = 1'b0;
    drain("stall");

    // 3: redirect during WAIT, 3-cycle memory
    do_reset();
    mem_lat = 3;
    exp_req.push_back(32'h0); exp_req.push_back(32'h100);
    push_id(32'h100, 32'h100);
    release_reset();
    wait_req(32'h0);
    @(negedge clk);
    redirect_pulse(32'h100);
    chk("rdw_valid", bus.id_valid_o, 32'd0);
    chk("rdw_instr", bus.id_instr_o, 32'h13);
    chk("rdw_addr", bus.imem_addr_o, 32'h100);
    chk("rdw_req", bus.imem_req_o, 32'd0);
    drain("redir_wait");

    // 3b: second redirect while the squash is still pending
    do_reset();
    mem_lat = 3;
    exp_req.push_back(32'h0); exp_req.push_back(32'h400);
    push_id(32'h400, 32'h400);
    release_reset();
    wait_req(32'h0);
    @(negedge clk);
    redirect_pulse(32'h300);
    redirect_pulse(32'h400);
    chk("rd2_addr", bus.imem_addr_o, 32'h400);
    drain("redir_twice");

    // 4a: redirect in the REQ cycle; old request still issued, data dropped
    do_reset();
    mem_lat = 1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h200);
    push_id(32'h200, 32'h200);
    release_reset();
    wait_req(32'h0);
    redirect_pulse(32'h200);
    chk("rdq_addr", bus.imem_addr_o, 32'h200);
    chk("rdq_req", bus.imem_req_o, 32'd0);
    chk("rdq_valid", bus.id_valid_o, 32'd0);
    drain("redir_req");

    // 4b: redirect coincident with rvalid, misaligned target
    do_reset();
    mem_lat = 1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h100);
    push_id(32'h100, 32'h100);
    release_reset();
    wait_req(32'h0);
    @(negedge clk);
    redirect_pulse(32'h103);
    chk("rdv_addr", bus.imem_addr_o, 32'h100);
    chk("rdv_valid", bus.id_valid_o, 32'd0);
    chk("rdv_instr", bus.id_instr_o, 32'h13);
    drain("redir_rvalid");

    // 5: PC wrap from 0xFFFF_FFFC on the second instance
    e2[0] = 32'hFFFF_FFFC;
    e2[1] = 32'h0000_0000;
    e2[2] = 32'h0000_0004;
    @(negedge clk);
    #2 rst2_n = 1'b1;
    got  = 0;
    nreq = 0;
    n    = 0;
    while (got < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus2.imem_req_o && nreq < 3) begin
        chk("wrap_req", bus2.imem_addr_o, e2[nreq]);
        nreq++;
      end
      if (bus2.id_valid_o) begin
        chk("wrap_pc", bus2.id_pc_o, e2[got]);
        chk("wrap_instr", bus2.id_instr_o, e2[got]);
        got++;
      end
    end
    chk("wrap_count", got, 32'd3);

    // 6: asynchronous reset during WAIT, late response afterwards
    do_reset();
    mem_lat  = 2;
    mem_keep = 1'b1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    push_id(32'h0, 32'h0); push_id(32'h4, 32'h4);
    release_reset();
    wait_req(32'h8);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", bus.imem_req_o, 32'd0);
    chk("arst_addr", bus.imem_addr_o, 32'h0);
    chk("arst_valid", bus.id_valid_o, 32'd0);
    chk("arst_instr", bus.id_instr_o, 32'h13);
    chk("arst_pc", bus.id_pc_o, 32'h0);
    chk("arst_queues", exp_id.size() + exp_req.size(), 32'd0);
    exp_req.push_back(32'h0);
    push_id(32'h0, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    drain("async_reset");
    mem_keep = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Delivers instruction/PC pairs to decode, where the immediate generator consumes them.
- Handles decode stall, branch/jump redirect, and squashing of in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP_INSTR, 32'h0000_0013, instruction word driven to decode on bubble/flush (ADDI x0,x0,0)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
stall_i  input  1  decode cannot accept; IF/ID holds
redirect_i  input  1  branch/JAL taken; flush and refetch
redirect_pc_i  input  32  redirect target
imem_req_o  output  1  one-cycle fetch request pulse
imem_addr_o  output  32  fetch address (word aligned)
imem_rdata_i  input  32  fetched instruction
imem_rvalid_i  input  1  one-cycle response strobe, ≥1 cycle after req; never unsolicited
id_valid_o  output  1  IF/ID holds a valid instruction
id_instr_o  output  32  IF/ID instruction
id_pc_o  output  32  IF/ID instruction address

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE, squash=0, buf cleared.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - id_valid_o=0, id_instr_o=NOP_INSTR, id_pc_o=0.
- imem_addr_o always equals pc.
- pc increment is 32-bit modulo: 0xFFFF_FFFC+4 → 0x0000_0000.
- States:
  - IDLE: first cycle after reset release; go to REQ.
  - REQ: imem_req_o=1 for exactly this cycle; go to WAIT.
  - WAIT: imem_req_o=0; wait for imem_rvalid_i.
    - rvalid with squash=1: drop data, clear squash, go to REQ.
    - rvalid with stall_i=0: IF/ID ← {valid=1, rdata, pc}; pc←pc+4; go to REQ.
    - rvalid with stall_i=1: buf←rdata; go to HOLD.
  - HOLD: when stall_i=0: IF/ID ← {1, buf, pc}; pc←pc+4; go to REQ.
- Peak throughput: one instruction per 2 cycles with 1-cycle memory latency.
- IF/ID update rules:
  - stall_i=1 and no redirect: all id_* hold their values.
  - stall_i=0 and no instruction loaded this cycle: id_valid_o←0, id_instr_o←NOP_INSTR, id_pc_o holds.
- Redirect (highest priority; overrides stall_i and any same-cycle rvalid):
  - id_valid_o←0, id_instr_o←NOP_INSTR.
  - pc←{redirect_pc_i[31:2],2'b00}.
  - IDLE/HOLD: buf discarded; next state REQ.
  - WAIT without rvalid: squash←1, stay WAIT.
  - WAIT with rvalid same cycle: response dropped; next state REQ.
  - REQ: the request at the old pc still goes out; squash←1; next WAIT.
- Second redirect while squash=1: pc updated again; squash stays 1.
- Only one request is ever outstanding; imem_req_o never asserts in WAIT or HOLD.
- Reset mid-transaction: all state returns to reset values immediately. A late rvalid arriving in IDLE/REQ is ignored.

Test Plan:
- Reset release, 1-cycle memory returning addr-as-data: req at 0x0,0x4,0x8 on every other cycle. id_pc_o/id_instr_o = 0x0,0x4,0x8; id_valid_o=1 on each load cycle, 0 between.
- stall_i=1 held 3 cycles while rvalid returns 0x00500093 at pc 0x8: IF/ID holds the previous instr, no new req. On release, id_instr_o=0x00500093, id_pc_o=0x8; next req addr 0xC.
- redirect_i=1, target 0x100, asserted during WAIT with 3-cycle latency: id_valid_o=0, id_instr_o=0x13. Stale response dropped; next req addr 0x100; first delivered id_pc_o=0x100.
- redirect in the REQ cycle and redirect coincident with rvalid: in each case the old-address data never reaches IF/ID; following fetch addr = target. Misaligned target 0x103 fetches 0x100.
- RESET_PC=0xFFFF_FFFC: fetches 0xFFFF_FFFC then 0x0000_0000.
- rst_n pulsed low during WAIT: outputs return to reset values asynchronously. After release, fetch restarts at RESET_PC; a late rvalid is ignored.
